// File: rtl/heap_access_arbiter_pkg.sv
// Shared types and constants for the heap access arbiter: FSM state encoding,
// command op codes and the heap's key extremes.
package heap_access_arbiter_pkg;

   localparam int unsigned HEAP_W_D = 32;
   localparam logic [HEAP_W_D-1:0] HEAP_MAX_VALUE = 32'hffff_ffff;
   localparam logic [HEAP_W_D-1:0] HEAP_MIN_VALUE = 32'h0000_0000;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_PUSH     = 3'd1,
      ST_POP      = 3'd2,
      ST_WAIT     = 3'd3,
      ST_EMPTYRSP = 3'd4,
      ST_CLR      = 3'd5
   } state_e;

   typedef enum logic {
      OP_PUSH = 1'b0,
      OP_POP  = 1'b1
   } op_e;

endpackage

// File: rtl/heap_access_arbiter_rr_select.sv
// Round-robin picker: first asserted request at or after ptr, wrapping modulo N_REQ.
module heap_access_arbiter_rr_select
   import heap_access_arbiter_pkg::*;
#(
   parameter int unsigned N_REQ = 4,
   parameter int unsigned W_ID  = 2
) (
   input  logic [N_REQ-1:0] req,
   input  logic [W_ID-1:0]  ptr,
   output logic [N_REQ-1:0] grant_c,
   output logic [W_ID-1:0]  idx_c,
   output logic             any_c
);

   always_comb begin : pick
      int unsigned cand;
      logic [W_ID-1:0] cand_idx;
      grant_c  = '0;
      idx_c    = '0;
      any_c    = 1'b0;
      cand     = 0;
      cand_idx = '0;
      for (int unsigned off = 0; off < N_REQ; off++) begin
         cand = int'(ptr) + off;
         if (cand >= N_REQ) cand = cand - N_REQ;
         cand_idx = W_ID'(cand);
         if (!any_c && req[cand_idx]) begin
            any_c             = 1'b1;
            grant_c[cand_idx] = 1'b1;
            idx_c             = cand_idx;
         end
      end
   end

endmodule

// File: rtl/heap_access_arbiter.sv
// Shares one heap priority queue between N_REQ requesters: round-robin push/pop
// serialisation, pop-result routing, local empty-pop answers and heap clear sequencing.
module heap_access_arbiter
   import heap_access_arbiter_pkg::*;
#(
   parameter int unsigned     N_REQ     = 4,
   parameter int unsigned     W_ID      = 2,
   parameter int unsigned     W_D       = 32,
   parameter logic [W_D-1:0]  EMPTY_VAL = W_D'(HEAP_MAX_VALUE)
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [N_REQ-1:0]     req_push,
   input  logic [N_REQ-1:0]     req_pop,
   input  logic [N_REQ*W_D-1:0] req_data,
   output logic [N_REQ-1:0]     req_grant,
   output logic [N_REQ-1:0]     resp_valid,
   output logic [W_D-1:0]       resp_data,
   output logic                 resp_empty,
   input  logic                 clear_req,
   output logic                 clear_done,
   output logic                 busy,
   output logic                 heap_write_valid,
   input  logic                 heap_write_ready,
   output logic [W_D-1:0]       heap_write_data,
   output logic                 heap_read_req_valid,
   input  logic                 heap_read_req_ready,
   input  logic                 heap_read_data_valid,
   input  logic [W_D-1:0]       heap_read_data,
   input  logic                 heap_read_empty,
   output logic                 heap_reset_state
);

   state_e           state_q, state_d;
   logic [W_ID-1:0]  ptr_q, ptr_d;
   logic [W_ID-1:0]  id_q, id_d;
   logic [N_REQ-1:0] grant_q, grant_d;
   logic [N_REQ-1:0] resp_valid_q, resp_valid_d;
   logic [W_D-1:0]   resp_data_q, resp_data_d;
   logic             resp_empty_q, resp_empty_d;
   logic             clear_done_q, clear_done_d;
   logic             clear_pending_q, clear_pending_d;
   logic             busy_q, busy_d;
   logic             write_valid_q, write_valid_d;
   logic [W_D-1:0]   write_data_q, write_data_d;
   logic             read_req_valid_q, read_req_valid_d;
   logic             reset_state_q, reset_state_d;

   logic [N_REQ-1:0] sel_req_c;
   logic [N_REQ-1:0] sel_grant_c;
   logic [W_ID-1:0]  sel_idx_c;
   logic             sel_any_c;
   logic [N_REQ-1:0] id_onehot_c;
   logic [W_D-1:0]   req_data_arr [N_REQ];

   for (genvar g = 0; g < N_REQ; g++) begin : g_slice
      assign req_data_arr[g] = req_data[g*W_D +: W_D];
   end

   // The requester whose grant is pulsing may still hold its request this cycle.
   assign sel_req_c   = (req_push | req_pop) & ~grant_q;
   assign id_onehot_c = N_REQ'(1) << id_q;

   heap_access_arbiter_rr_select #(
      .N_REQ (N_REQ),
      .W_ID  (W_ID)
   ) u_rr_select (
      .req     (sel_req_c),
      .ptr     (ptr_q),
      .grant_c (sel_grant_c),
      .idx_c   (sel_idx_c),
      .any_c   (sel_any_c)
   );

   always_comb begin
      state_d          = state_q;
      ptr_d            = ptr_q;
      id_d             = id_q;
      grant_d          = '0;
      resp_valid_d     = '0;
      resp_data_d      = resp_data_q;
      resp_empty_d     = resp_empty_q;
      clear_done_d     = 1'b0;
      clear_pending_d  = clear_pending_q | clear_req;
      write_valid_d    = write_valid_q;
      write_data_d     = write_data_q;
      read_req_valid_d = read_req_valid_q;
      reset_state_d    = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (clear_pending_q) begin
               state_d = ST_CLR;
            end else if (sel_any_c) begin
               id_d  = sel_idx_c;
               ptr_d = (sel_idx_c == W_ID'(N_REQ - 1)) ? '0 : sel_idx_c + W_ID'(1);
               if (req_push[sel_idx_c]) begin
                  write_valid_d = 1'b1;
                  write_data_d  = req_data_arr[sel_idx_c];
                  state_d       = ST_PUSH;
               end else if (heap_read_empty) begin
                  state_d = ST_EMPTYRSP;
               end else begin
                  read_req_valid_d = 1'b1;
                  state_d          = ST_POP;
               end
            end
         end
         ST_PUSH: begin
            if (heap_write_ready) begin
               grant_d       = id_onehot_c;
               write_valid_d = 1'b0;
               state_d       = ST_IDLE;
            end
         end
         ST_POP: begin
            if (heap_read_req_ready) begin
               grant_d          = id_onehot_c;
               read_req_valid_d = 1'b0;
               state_d          = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (heap_read_data_valid) begin
               resp_data_d  = heap_read_data;
               resp_empty_d = 1'b0;
               resp_valid_d = id_onehot_c;
               state_d      = ST_IDLE;
            end
         end
         ST_EMPTYRSP: begin
            grant_d      = id_onehot_c;
            resp_valid_d = id_onehot_c;
            resp_data_d  = EMPTY_VAL;
            resp_empty_d = 1'b1;
            state_d      = ST_IDLE;
         end
         ST_CLR: begin
            // Only reset the heap once it is idle and able to accept.
            if (heap_write_ready) begin
               reset_state_d   = 1'b1;
               clear_done_d    = 1'b1;
               clear_pending_d = clear_req;
               state_d         = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q          <= ST_IDLE;
         ptr_q            <= '0;
         id_q             <= '0;
         grant_q          <= '0;
         resp_valid_q     <= '0;
         resp_data_q      <= '0;
         resp_empty_q     <= 1'b0;
         clear_done_q     <= 1'b0;
         clear_pending_q  <= 1'b0;
         busy_q           <= 1'b0;
         write_valid_q    <= 1'b0;
         write_data_q     <= '0;
         read_req_valid_q <= 1'b0;
         reset_state_q    <= 1'b0;
      end else begin
         state_q          <= state_d;
         ptr_q            <= ptr_d;
         id_q             <= id_d;
         grant_q          <= grant_d;
         resp_valid_q     <= resp_valid_d;
         resp_data_q      <= resp_data_d;
         resp_empty_q     <= resp_empty_d;
         clear_done_q     <= clear_done_d;
         clear_pending_q  <= clear_pending_d;
         busy_q           <= busy_d;
         write_valid_q    <= write_valid_d;
         write_data_q     <= write_data_d;
         read_req_valid_q <= read_req_valid_d;
         reset_state_q    <= reset_state_d;
      end
   end

   assign req_grant           = grant_q;
   assign resp_valid          = resp_valid_q;
   assign resp_data           = resp_data_q;
   assign resp_empty          = resp_empty_q;
   assign clear_done          = clear_done_q;
   assign busy                = busy_q;
   assign heap_write_valid    = write_valid_q;
   assign heap_write_data     = write_data_q;
   assign heap_read_req_valid = read_req_valid_q;
   assign heap_reset_state    = reset_state_q;

endmodule

// File: tb/tb_heap_access_arbiter.sv
// Directed bench for heap_access_arbiter: push, pop, empty pop, fairness,
// back-pressure, clear behind an in-flight pop and asynchronous reset.
module tb_heap_access_arbiter;

   localparam int unsigned N_REQ = 4;
   localparam int unsigned W_ID  = 2;
   localparam int unsigned W_D   = 32;

   logic                 CLK;
   logic                 RST_N;
   logic [N_REQ-1:0]     req_push;
   logic [N_REQ-1:0]     req_pop;
   logic [N_REQ*W_D-1:0] req_data;
   logic [N_REQ-1:0]     req_grant;
   logic [N_REQ-1:0]     resp_valid;
   logic [W_D-1:0]       resp_data;
   logic                 resp_empty;
   logic                 clear_req;
   logic                 clear_done;
   logic                 busy;
   logic                 heap_write_valid;
   logic                 heap_write_ready;
   logic [W_D-1:0]       heap_write_data;
   logic                 heap_read_req_valid;
   logic                 heap_read_req_ready;
   logic                 heap_read_data_valid;
   logic [W_D-1:0]       heap_read_data;
   logic                 heap_read_empty;
   logic                 heap_reset_state;

   int passed;
   int total;

   heap_access_arbiter #(
      .N_REQ     (N_REQ),
      .W_ID      (W_ID),
      .W_D       (W_D),
      .EMPTY_VAL (32'hffff_ffff)
   ) dut (
      .CLK                  (CLK),
      .RST_N                (RST_N),
      .req_push             (req_push),
      .req_pop              (req_pop),
      .req_data             (req_data),
      .req_grant            (req_grant),
      .resp_valid           (resp_valid),
      .resp_data            (resp_data),
      .resp_empty           (resp_empty),
      .clear_req            (clear_req),
      .clear_done           (clear_done),
      .busy                 (busy),
      .heap_write_valid     (heap_write_valid),
      .heap_write_ready     (heap_write_ready),
      .heap_write_data      (heap_write_data),
      .heap_read_req_valid  (heap_read_req_valid),
      .heap_read_req_ready  (heap_read_req_ready),
      .heap_read_data_valid (heap_read_data_valid),
      .heap_read_data       (heap_read_data),
      .heap_read_empty      (heap_read_empty),
      .heap_reset_state     (heap_reset_state)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Heap answers an accepted pop one cycle later.
   always @(posedge CLK or negedge RST_N) begin
      if (!RST_N) heap_read_data_valid <= 1'b0;
      else        heap_read_data_valid <= heap_read_req_valid & heap_read_req_ready;
   end

   task automatic tick();
      @(posedge CLK);
      @(negedge CLK);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total = total + 1;
      assert (obs === exp) passed = passed + 1;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   initial begin
      logic [W_D-1:0] pdata [4];
      passed = 0;
      total  = 0;
      pdata[0] = 32'h0000_00a0;
      pdata[1] = 32'h0000_00a1;
      pdata[2] = 32'h0000_00a2;
      pdata[3] = 32'h0000_00a3;

      RST_N               = 1'b0;
      req_push            = '0;
      req_pop             = '0;
      req_data            = '0;
      clear_req           = 1'b0;
      heap_write_ready    = 1'b0;
      heap_read_req_ready = 1'b0;
      heap_read_data      = '0;
      heap_read_empty     = 1'b0;

      // Reset state
      @(negedge CLK);
      @(negedge CLK);
      chk("rst_grant", 64'(req_grant), 64'h0);
      chk("rst_resp_valid", 64'(resp_valid), 64'h0);
      chk("rst_busy", 64'(busy), 64'h0);
      chk("rst_heap_ctrl", 64'({heap_write_valid, heap_read_req_valid, heap_reset_state, clear_done}), 64'h0);
      RST_N               = 1'b1;
      heap_write_ready    = 1'b1;
      heap_read_req_ready = 1'b1;

      // Single push from requester 2
      req_push = 4'b0100;
      req_data[2*W_D +: W_D] = 32'h10;
      tick();
      chk("push_wvalid", 64'(heap_write_valid), 64'h1);
      chk("push_wdata", 64'(heap_write_data), 64'h10);
      chk("push_busy", 64'(busy), 64'h1);
      chk("push_no_early_grant", 64'(req_grant), 64'h0);
      tick();
      chk("push_grant", 64'(req_grant), 64'h4);
      chk("push_wvalid_drop", 64'(heap_write_valid), 64'h0);
      chk("push_busy_drop", 64'(busy), 64'h0);
      tick();
      chk("push_grant_once", 64'(req_grant), 64'h0);
      chk("push_no_reserve", 64'(busy), 64'h0);
      req_push = '0;

      // Pop round-trip from requester 1, heap holds 0x05
      heap_read_data = 32'h05;
      req_pop = 4'b0010;
      tick();
      chk("pop_rreq_valid", 64'(heap_read_req_valid), 64'h1);
      chk("pop_no_wvalid", 64'(heap_write_valid), 64'h0);
      tick();
      chk("pop_grant", 64'(req_grant), 64'h2);
      chk("pop_rreq_drop", 64'(heap_read_req_valid), 64'h0);
      req_pop = '0;
      tick();
      chk("pop_resp_valid", 64'(resp_valid), 64'h2);
      chk("pop_resp_data", 64'(resp_data), 64'h05);
      chk("pop_resp_empty", 64'(resp_empty), 64'h0);

      // Pop on an empty heap from requester 3
      heap_read_empty = 1'b1;
      req_pop = 4'b1000;
      tick();
      chk("epop_no_rreq", 64'(heap_read_req_valid), 64'h0);
      chk("epop_busy", 64'(busy), 64'h1);
      tick();
      chk("epop_grant", 64'(req_grant), 64'h8);
      chk("epop_resp_valid", 64'(resp_valid), 64'h8);
      chk("epop_resp_data", 64'(resp_data), 64'hffff_ffff);
      chk("epop_resp_empty", 64'(resp_empty), 64'h1);
      req_pop = '0;
      heap_read_empty = 1'b0;
      tick();
      chk("epop_idle", 64'({busy, heap_read_req_valid}), 64'h0);

      // Fairness: all four push continuously, pointer back at 0
      req_push = 4'b1111;
      for (int r = 0; r < 4; r++) req_data[r*W_D +: W_D] = pdata[r];
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("fair_wdata", 64'(heap_write_data), 64'(pdata[k % 4]));
         tick();
         chk("fair_grant", 64'(req_grant), 64'(4'b0001 << (k % 4)));
      end
      req_push = '0;
      tick();
      chk("fair_idle", 64'(busy), 64'h0);

      // Back-pressure on push from requester 0 (pointer at 1, wraps to 0)
      heap_write_ready = 1'b0;
      req_push = 4'b0001;
      req_data[0 +: W_D] = 32'h0000_abcd;
      tick();
      for (int c = 0; c < 5; c++) begin
         chk("bp_hold", 64'({heap_write_valid, heap_write_data, req_grant}), {27'h0, 1'b1, 32'h0000_abcd, 4'h0});
         tick();
      end
      heap_write_ready = 1'b1;
      tick();
      chk("bp_grant", 64'(req_grant), 64'h1);
      chk("bp_wvalid_drop", 64'(heap_write_valid), 64'h0);
      req_push = '0;

      // Clear requested while a pop from requester 2 is waiting for data
      heap_read_data = 32'h77;
      req_pop = 4'b0100;
      tick();
      chk("clr_pop_issue", 64'(heap_read_req_valid), 64'h1);
      tick();
      chk("clr_pop_grant", 64'(req_grant), 64'h4);
      req_pop = '0;
      clear_req = 1'b1;
      tick();
      clear_req = 1'b0;
      chk("clr_resp_first", 64'({resp_valid, resp_data}), {28'h0, 4'h4, 32'h77});
      chk("clr_not_yet", 64'({heap_reset_state, clear_done}), 64'h0);
      tick();
      chk("clr_busy", 64'({busy, heap_reset_state}), 64'h2);
      tick();
      chk("clr_pulse", 64'({heap_reset_state, clear_done}), 64'h3);
      chk("clr_exclusive", 64'({heap_write_valid, heap_read_req_valid}), 64'h0);
      tick();
      chk("clr_one_cycle", 64'({heap_reset_state, clear_done, busy}), 64'h0);

      // Asynchronous reset while a push waits in PUSH
      heap_write_ready = 1'b0;
      req_push = 4'b0010;
      req_data[1*W_D +: W_D] = 32'h33;
      tick();
      chk("ar_in_push", 64'(heap_write_valid), 64'h1);
      #2;
      RST_N = 1'b0;
      #1;
      chk("ar_outputs_zero", 64'({heap_write_valid, busy, heap_read_req_valid, heap_reset_state, clear_done, resp_empty}), 64'h0);
      chk("ar_data_zero", 64'({heap_write_data, req_grant, resp_valid}), 64'h0);
      req_push = '0;
      @(negedge CLK);
      RST_N = 1'b1;
      tick();
      chk("ar_stay_idle", 64'(busy), 64'h0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
